// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 24-bit x 16 register file: zero-fill sweep after reset, then round-robin ALU/MEM writeback.
// Optional REGFILE_R0_ZERO_EN: grants targeting register 0 handshake normally but never assert RegWrite.
module regfile_write_arbiter #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_aluValid,
  input  logic [ADDR_W-1:0] i_aluRd,
  input  logic [DATA_W-1:0] i_aluData,
  output logic              o_aluReady,
  input  logic              i_memValid,
  input  logic [ADDR_W-1:0] i_memRd,
  input  logic [DATA_W-1:0] i_memData,
  output logic              o_memReady,
  output logic [ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0] o_writeData,
  output logic              o_regWrite,
  output logic              o_initDone
);

  localparam logic            STATE_INIT   = 1'b0;
  localparam logic            STATE_RUN    = 1'b1;
  localparam logic [ADDR_W:0] LP_SWEEP_LEN = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LP_IDX_ONE   = (ADDR_W + 1)'(1);

  logic              r_state;
  logic [ADDR_W:0]   r_idx;
  logic              r_prioMem;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_writeData;
  logic              r_regWrite;
  logic              r_initDone;

  logic              w_aluReady;
  logic              w_memReady;
  logic              w_aluFire;
  logic              w_memFire;
  logic [ADDR_W-1:0] w_grantRd;
  logic [DATA_W-1:0] w_grantData;
  logic              w_grantWrites;

  // Only one ready can be high when both requesters are valid, so at most one handshake per cycle.
  assign w_aluReady  = r_initDone & (~i_memValid | ~r_prioMem);
  assign w_memReady  = r_initDone & (~i_aluValid |  r_prioMem);
  assign w_aluFire   = i_aluValid & w_aluReady;
  assign w_memFire   = i_memValid & w_memReady;
  assign w_grantRd   = w_aluFire ? i_aluRd   : i_memRd;
  assign w_grantData = w_aluFire ? i_aluData : i_memData;

`ifdef REGFILE_R0_ZERO_EN
  assign w_grantWrites = (w_grantRd != '0);
`else
  assign w_grantWrites = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= STATE_INIT;
      r_idx       <= '0;
      r_prioMem   <= 1'b0;
      r_rd        <= '0;
      r_writeData <= '0;
      r_regWrite  <= 1'b0;
      r_initDone  <= 1'b0;
    end else begin
      case (r_state)
        STATE_INIT: begin
          if (r_idx < LP_SWEEP_LEN) begin
            r_regWrite  <= 1'b1;
            r_rd        <= r_idx[ADDR_W-1:0];
            r_writeData <= '0;
            r_idx       <= r_idx + LP_IDX_ONE;
          end else begin
            r_regWrite <= 1'b0;
            r_initDone <= 1'b1;
            r_state    <= STATE_RUN;
          end
        end
        STATE_RUN: begin
          r_regWrite <= 1'b0;
          // Priority passes to the loser of every grant, even an uncontested one.
          if (w_aluFire || w_memFire) begin
            r_prioMem <= w_aluFire;
            if (w_grantWrites) begin
              r_regWrite  <= 1'b1;
              r_rd        <= w_grantRd;
              r_writeData <= w_grantData;
            end
          end
        end
        default: r_state <= STATE_INIT;
      endcase
    end
  end

  assign o_aluReady  = w_aluReady;
  assign o_memReady  = w_memReady;
  assign o_rd        = r_rd;
  assign o_writeData = r_writeData;
  assign o_regWrite  = r_regWrite;
  assign o_initDone  = r_initDone;

endmodule
